// File: rtl/key_debounce_if.sv
// Button event bus between the debouncer and its consumers: the raw pin in,
// clean single-cycle events and the debounced level out.
interface key_debounce_if;
    logic key_in;
    logic press;
    logic key_release;
    logic long_press;
    logic key_state;

    modport master (
        output key_in,
        input  press,
        input  key_release,
        input  long_press,
        input  key_state
    );

    modport slave (
        input  key_in,
        output press,
        output key_release,
        output long_press,
        output key_state
    );
endinterface

// File: rtl/key_debounce.sv
// Push-button conditioner: synchronises the raw pin, rejects contact bounce and
// emits registered press / release / long-press pulses plus a debounced level.
module key_debounce #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000,
    parameter bit ACTIVE_LOW  = 1'b0
) (
    input logic         clk,
    input logic         rst_n,
    key_debounce_if.slave btn
);
    localparam int DB   = CLK_FREQ_HZ / 1000 * DEBOUNCE_MS;
    localparam int LG   = CLK_FREQ_HZ / 1000 * LONG_MS;
    localparam int DB_W = $clog2(DB);
    localparam int LG_W = $clog2(LG);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB - 1);
    localparam logic [LG_W-1:0] LG_LAST = LG_W'(LG - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    state_t          state_q;
    logic            sync1_q;
    logic            ks_q;
    logic [DB_W-1:0] db_cnt_q;
    logic [LG_W-1:0] hold_cnt_q;
    logic [LG_W-1:0] hold_cnt_d;
    logic            long_done_q;
    logic            press_q;
    logic            release_q;
    logic            long_press_q;
    logic            key_state_q;

    // Two-flop synchroniser on the polarity-corrected pin; idles at "not pressed".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            ks_q    <= 1'b0;
        end else begin
            sync1_q <= btn.key_in ^ ACTIVE_LOW;
            ks_q    <= sync1_q;
        end
    end

    // Hold time saturates so an indefinitely held key cannot wrap and re-fire.
    always_comb begin
        hold_cnt_d = (hold_cnt_q == LG_LAST) ? hold_cnt_q : hold_cnt_q + LG_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            db_cnt_q     <= '0;
            hold_cnt_q   <= '0;
            long_done_q  <= 1'b0;
            press_q      <= 1'b0;
            release_q    <= 1'b0;
            long_press_q <= 1'b0;
            key_state_q  <= 1'b0;
        end else begin
            press_q      <= 1'b0;
            release_q    <= 1'b0;
            long_press_q <= 1'b0;

            // Long-press timing keeps running through a pending release.
            if (state_q == HELD || state_q == RELEASE_WAIT) begin
                hold_cnt_q <= hold_cnt_d;
                if (hold_cnt_d == LG_LAST && !long_done_q) begin
                    long_press_q <= 1'b1;
                    long_done_q  <= 1'b1;
                end
            end

            case (state_q)
                IDLE: begin
                    if (ks_q) begin
                        state_q  <= PRESS_WAIT;
                        db_cnt_q <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!ks_q) begin
                        state_q <= IDLE;
                    end else if (db_cnt_q == DB_LAST) begin
                        state_q     <= HELD;
                        press_q     <= 1'b1;
                        key_state_q <= 1'b1;
                        hold_cnt_q  <= '0;
                        long_done_q <= 1'b0;
                    end else begin
                        db_cnt_q <= db_cnt_q + DB_W'(1);
                    end
                end
                HELD: begin
                    if (!ks_q) begin
                        state_q  <= RELEASE_WAIT;
                        db_cnt_q <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (ks_q) begin
                        state_q <= HELD;
                    end else if (db_cnt_q == DB_LAST) begin
                        state_q     <= IDLE;
                        release_q   <= 1'b1;
                        key_state_q <= 1'b0;
                    end else begin
                        db_cnt_q <= db_cnt_q + DB_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign btn.press       = press_q;
    assign btn.key_release = release_q;
    assign btn.long_press  = long_press_q;
    assign btn.key_state   = key_state_q;
endmodule
